// File: rtl/uart_rx_cfg.sv
// UART receiver with 2-of-3 mid-bit majority sampling and a ready/valid output holding register.
// Optional parity checking is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RX,
  input  logic                 RX_READY,
  output logic                 RX_VALID,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN
);

  localparam int H = CLKS_PER_BIT / 2;
  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_H_M1 = 16'(H - 1);
  localparam logic [15:0] CNT_H    = 16'(H);
  localparam logic [15:0] CNT_H_P1 = 16'(H + 1);
  localparam logic [3:0]  IDX_LAST = 4'(DATA_BITS - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic                 rx_meta_reg;
  logic                 rxs_reg;
  logic [2:0]           state_reg;
  logic [15:0]          cnt_reg;
  logic [3:0]           idx_reg;
  logic                 stop_idx_reg;
  logic                 s0_reg;
  logic                 s1_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 ferr_reg;

  logic maj;
  logic at_wrap;
  logic at_dec;
  logic done_load;

  // Majority of the two earlier samples and the live sample at the decision point
  assign maj       = (s0_reg & s1_reg) | (s0_reg & rxs_reg) | (s1_reg & rxs_reg);
  assign at_wrap   = (cnt_reg == CNT_LAST);
  assign at_dec    = (cnt_reg == CNT_H_P1);
  assign done_load = (state_reg == DONE) && (!RX_VALID || RX_READY);

`ifdef UART_RX_PARITY_EN
  logic perr_reg;
  logic parity_err_reg;
  logic par_exp;

  assign par_exp    = (^shift_reg) ^ (PARITY_ODD != 0);
  assign PARITY_ERR = parity_err_reg;
`else
  logic unused_parity_odd;

  assign unused_parity_odd = (PARITY_ODD != 0);
  assign PARITY_ERR        = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_meta_reg  <= 1'b1;
      rxs_reg      <= 1'b1;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      stop_idx_reg <= 1'b0;
      s0_reg       <= 1'b1;
      s1_reg       <= 1'b1;
      shift_reg    <= '0;
      ferr_reg     <= 1'b0;
      RX_VALID     <= 1'b0;
      RX_DATA      <= '0;
      FRAME_ERR    <= 1'b0;
      OVERRUN      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_reg       <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      rx_meta_reg <= RX;
      rxs_reg     <= rx_meta_reg;
      OVERRUN     <= 1'b0;

      if (RX_VALID && RX_READY)
        RX_VALID <= 1'b0;

      if (state_reg != IDLE)
        cnt_reg <= at_wrap ? '0 : cnt_reg + 16'd1;
      if (cnt_reg == CNT_H_M1)
        s0_reg <= rxs_reg;
      if (cnt_reg == CNT_H)
        s1_reg <= rxs_reg;

      case (state_reg)
        IDLE: begin
          if (!rxs_reg) begin
            state_reg <= START;
            cnt_reg   <= '0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_reg  <= 1'b0;
`endif
          end
        end
        START: begin
          if (at_dec && maj) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (at_wrap) begin
            state_reg <= DATA;
            idx_reg   <= '0;
          end
        end
        DATA: begin
          // LSB arrives first, so shifting in at the top leaves bit 0 at the bottom
          if (at_dec)
            shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
          if (at_wrap) begin
            idx_reg      <= idx_reg + 4'd1;
            stop_idx_reg <= 1'b0;
            if (idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_dec && (maj != par_exp))
            perr_reg <= 1'b1;
          if (at_wrap)
            state_reg <= STOP;
        end
`endif
        STOP: begin
          if (at_dec) begin
            if (!maj)
              ferr_reg <= 1'b1;
            if (stop_idx_reg == STOP_LAST) begin
              state_reg <= DONE;
              cnt_reg   <= '0;
            end
          end else if (at_wrap) begin
            stop_idx_reg <= stop_idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (done_load) begin
            RX_DATA   <= shift_reg;
            FRAME_ERR <= ferr_reg;
            RX_VALID  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= perr_reg;
`endif
          end else begin
            OVERRUN <= 1'b1;
          end
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, CLK cycles per bit (100 MHz / 9600); legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 even, 1 odd; used only with UART_RX_PARITY_EN.
REQ-005 SHALL have port CLK  input  1  clock; all logic on posedge.
REQ-006 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port RX  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port RX_READY  input  1  consumer accepts the held word.
REQ-009 SHALL have port RX_VALID  output  1  held word is available.
REQ-010 SHALL have port RX_DATA  output  DATA_BITS  received word, LSB first on the line.
REQ-011 SHALL have port FRAME_ERR  output  1  stop-bit error flag for the held word.
REQ-012 SHALL have port PARITY_ERR  output  1  parity error flag for the held word.
REQ-013 SHALL have port OVERRUN  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-014 SHALL pass RX through a two-flop synchronizer; all sampling uses the synchronized value (rxs).
REQ-015 SHALL use states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-016 SHALL use a bit counter running 0..CLKS_PER_BIT-1 and wrapping to 0 at each bit boundary; H = CLKS_PER_BIT/2, truncated.
REQ-017 SHALL sample rxs at counter H-1, H and H+1 and take the 2-of-3 majority as the bit value, decided at counter H+1.
REQ-018 IDLE: on rxs==0, go to START with counter=0.
REQ-019 START: majority 1 means false start: return to IDLE at counter H+1; majority 0 means go to DATA at wrap with bit index 0.
REQ-020 DATA: store the majority into RX_DATA bit[index]; at wrap, increment index; after index DATA_BITS-1, go to PARITY if enabled, else STOP.
REQ-021 PARITY: compare the majority against the computed parity; a mismatch sets internal perr; go to STOP at wrap.
REQ-022 STOP: a majority of 0 on any stop bit sets internal ferr; after the last stop bit's decision at H+1, go to DONE immediately, without waiting for wrap.
REQ-023 DONE (one cycle): if RX_VALID==0 or RX_READY==1, load RX_DATA, FRAME_ERR and PARITY_ERR from the frame and set RX_VALID=1; otherwise drop the frame, keep the old word and pulse OVERRUN=1. Then go to IDLE.
REQ-024 Handshake: RX_VALID SHALL clear on the cycle after RX_VALID&&RX_READY, unless a DONE load happens in that cycle, in which case RX_VALID stays 1 with the new word.
REQ-025 RX_DATA, FRAME_ERR and PARITY_ERR SHALL remain stable while RX_VALID==1 and not accepted.
REQ-026 A frame with ferr or perr SHALL still be delivered, with its flag set.
REQ-027 Frame-to-DONE latency SHALL be at most (1+DATA_BITS+P+STOP_BITS-1)*CLKS_PER_BIT+H+4 cycles from the RX falling edge, where P=1 if parity is enabled and 0 otherwise.

Reset
REQ-028 RESET SHALL force state to IDLE, counter and index to 0, RX_VALID, FRAME_ERR, PARITY_ERR and OVERRUN to 0, RX_DATA to 0, and the synchronizer flops to 1.
REQ-029 RESET asserted mid-frame SHALL abandon the frame with no output; reception SHALL restart on the next falling edge after release.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: the PARITY state is compiled in, one parity bit is expected after the data bits, and PARITY_ERR is driven per REQ-021.
REQ-031 Macro UART_RX_PARITY_EN undefined: no PARITY state or parity logic, DATA goes directly to STOP, and PARITY_ERR is tied 0.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-032 Frame 0xA5, RX_READY=1 -> RX_VALID=1 with RX_DATA=0xA5, FRAME_ERR=0; RX_VALID clears the next cycle.
REQ-033 RX low for 6 cycles then high -> returns to IDLE, RX_VALID never set; a following frame 0x3C is received correctly.
REQ-034 Frame 0x55 with stop bit driven 0 -> RX_DATA=0x55 with FRAME_ERR=1.
REQ-035 Two back-to-back frames 0x11 and 0x22 with RX_READY=0 -> 0x11 held, OVERRUN pulses once; after RX_READY=1, RX_VALID falls.
REQ-036 Parity enabled, PARITY_ODD=0, frame 0x07 with parity bit 0 -> PARITY_ERR=1; with parity bit 1 -> PARITY_ERR=0.
REQ-037 RESET pulsed at DATA bit 3 of a frame -> no RX_VALID; a following frame 0xF0 is received correctly.
